// File: rtl/inst_fetch_pkg.sv
// Shared types and encodings for the instruction-fetch stage.
//   inst_addr_t / inst_t : 32-bit instruction address and instruction words
//   NOP_INST_ENC         : addi x0,x0,0, shown on inst during bubbles
//   if_state_e           : 2-bit fetch FSM encoding
//   align4()             : clears the byte-offset bits of a fetch address
package inst_fetch_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [INST_W-1:0]      inst_t;

    localparam inst_t NOP_INST_ENC = 32'h0000_0013;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_FETCH = 2'd1,
        IF_HOLD  = 2'd2,
        IF_DROP  = 2'd3
    } if_state_e;

    function automatic inst_addr_t align4(input inst_addr_t a);
        return a & ~inst_addr_t'(3);
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-memory request/acknowledge port.
//   mem_req   : fetch request, held with mem_addr stable until mem_ack
//   mem_addr  : word-aligned fetch address
//   mem_ack   : request completes this cycle (may coincide with mem_req)
//   mem_rdata : instruction word, meaningful only while mem_ack is high
// master = fetch stage, slave = instruction memory.
interface inst_fetch_if;
    import inst_fetch_pkg::*;

    logic       mem_req;
    inst_addr_t mem_addr;
    logic       mem_ack;
    inst_t      mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/fetch_skid.sv
// One-entry pc+inst holding register used to park a fetched instruction
// while decode is stalled.
//   clk, rst_n      : clock, async active-low reset
//   load            : capture d_pc/d_inst, mark valid
//   flush           : mark empty
//   d_pc, d_inst    : entry to capture
//   q_pc, q_inst    : held entry
//   valid           : entry holds an instruction not yet handed to decode
module fetch_skid
    import inst_fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       flush,
    input  inst_addr_t d_pc,
    input  inst_t      d_inst,
    output inst_addr_t q_pc,
    output inst_t      q_inst,
    output logic       valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_pc   <= '0;
            q_inst <= '0;
            valid  <= 1'b0;
        end else if (load) begin
            q_pc   <= d_pc;
            q_inst <= d_inst;
            valid  <= 1'b1;
        end else if (flush) begin
            valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC generation, instruction-memory handshake,
// redirect squashing and a one-entry skid for decode stalls.
//   clk, rst_n         : clock, async active-low reset
//   stall              : decode cannot accept; pc/inst/inst_valid hold
//   br, br_addr        : redirect from decode, honoured when inst_valid & !stall
//   imem               : instruction-memory port (master side)
//   pc, inst           : instruction slot presented to decode
//   inst_valid         : slot holds a real instruction, not a bubble
//
// state    | meaning
// IF_IDLE  | one cycle after reset, no request
// IF_FETCH | request at fpc outstanding
// IF_HOLD  | decode stalled with a full slot; skid holds the next instruction
// IF_DROP  | finishing a squashed request at drop_addr, data discarded
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter inst_addr_t RESET_PC = 32'h0000_0000,
    parameter inst_t      NOP_INST = NOP_INST_ENC
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               br,
    input  inst_addr_t         br_addr,
    inst_fetch_if.master       imem,
    output inst_addr_t         pc,
    output inst_t              inst,
    output logic               inst_valid
);

    if_state_e  state, state_nxt;
    inst_addr_t fpc, fpc_nxt;
    inst_addr_t pc_nxt;
    inst_t      inst_nxt;
    logic       valid_nxt;
    inst_addr_t drop_addr, drop_nxt;

    logic       sk_load, sk_flush, sk_valid;
    inst_addr_t sk_pc;
    inst_t      sk_inst;

    // decode only acts on a branch it actually consumes this cycle
    logic redirect;
    assign redirect = br & inst_valid & ~stall;

    fetch_skid u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (sk_load),
        .flush  (sk_flush),
        .d_pc   (fpc),
        .d_inst (imem.mem_rdata),
        .q_pc   (sk_pc),
        .q_inst (sk_inst),
        .valid  (sk_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IF_IDLE;
            fpc        <= RESET_PC;
            pc         <= RESET_PC;
            inst       <= NOP_INST;
            inst_valid <= 1'b0;
            drop_addr  <= '0;
        end else begin
            state      <= state_nxt;
            fpc        <= fpc_nxt;
            pc         <= pc_nxt;
            inst       <= inst_nxt;
            inst_valid <= valid_nxt;
            drop_addr  <= drop_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fpc_nxt   = fpc;
        pc_nxt    = pc;
        inst_nxt  = inst;
        valid_nxt = inst_valid;
        drop_nxt  = drop_addr;
        sk_load   = 1'b0;
        sk_flush  = 1'b0;
        case (state)
            IF_IDLE: state_nxt = IF_FETCH;
            IF_FETCH: begin
                if (redirect) begin
                    fpc_nxt   = align4(br_addr);
                    inst_nxt  = NOP_INST;
                    valid_nxt = 1'b0;
                    // an unfinished wrong-path request must still complete
                    if (!imem.mem_ack) begin
                        drop_nxt  = fpc;
                        state_nxt = IF_DROP;
                    end
                end else if (imem.mem_ack && (!stall || !inst_valid)) begin
                    pc_nxt    = fpc;
                    inst_nxt  = imem.mem_rdata;
                    valid_nxt = 1'b1;
                    fpc_nxt   = fpc + 32'd4;
                end else if (imem.mem_ack) begin
                    sk_load   = 1'b1;
                    fpc_nxt   = fpc + 32'd4;
                    state_nxt = IF_HOLD;
                end else if (!stall) begin
                    inst_nxt  = NOP_INST;
                    valid_nxt = 1'b0;
                end
            end
            IF_HOLD: begin
                if (!stall) begin
                    sk_flush  = 1'b1;
                    state_nxt = IF_FETCH;
                    if (redirect) begin
                        fpc_nxt   = align4(br_addr);
                        inst_nxt  = NOP_INST;
                        valid_nxt = 1'b0;
                    end else if (sk_valid) begin
                        pc_nxt    = sk_pc;
                        inst_nxt  = sk_inst;
                        valid_nxt = 1'b1;
                    end
                end
            end
            IF_DROP: begin
                if (imem.mem_ack) state_nxt = IF_FETCH;
                if (!stall) begin
                    inst_nxt  = NOP_INST;
                    valid_nxt = 1'b0;
                end
            end
            default: state_nxt = IF_IDLE;
        endcase
    end

    always_comb begin
        imem.mem_req  = 1'b0;
        imem.mem_addr = fpc;
        case (state)
            IF_FETCH: imem.mem_req = 1'b1;
            IF_DROP: begin
                imem.mem_req  = 1'b1;
                imem.mem_addr = drop_addr;
            end
            default: imem.mem_req = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: cycle vector table plus hand-written
// latency, squash, wrap and reset sequences, with a scoreboard of the
// instructions decode should consume.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam logic [31:0] KEY = 32'hA5A5_A5A5;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [31:0] br_addr = '0;
    logic [31:0] pc, inst;
    logic        inst_valid;

    inst_fetch_if bus();

    inst_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .br         (br),
        .br_addr    (br_addr),
        .imem       (bus),
        .pc         (pc),
        .inst       (inst),
        .inst_valid (inst_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } sb_t;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] br_addr;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    sb_t         exp_q[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          mem_lat = 0;
    int          mem_wait = 0;
    logic        mem_busy = 1'b0;
    logic [31:0] mem_hold = '0;
    logic        squash = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    task automatic clear_model();
        exp_q.delete();
        mem_busy = 1'b0;
        mem_wait = 0;
        squash   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        br = 1'b0;
        br_addr = '0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Called 1 time unit after a rising edge: responds as memory, plays
    // decode, keeps the scoreboard, then advances to the next sample point.
    task automatic step(input logic s, input logic b, input logic [31:0] ba);
        logic        ack;
        logic [31:0] rd;
        logic        consume;
        sb_t         e;
        ack = 1'b0;
        rd  = 32'hDEAD_BEEF;
        if (!inst_valid) check("bubble_inst", inst, NOP);
        if (bus.mem_req) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_wait = 0;
                mem_hold = bus.mem_addr;
            end else begin
                check("req_addr_stable", bus.mem_addr, mem_hold);
            end
            if (mem_wait >= mem_lat) begin
                ack = 1'b1;
                rd  = bus.mem_addr ^ KEY;
                mem_busy = 1'b0;
            end else begin
                mem_wait++;
            end
        end else if (mem_busy) begin
            check("req_held", 32'(bus.mem_req), 32'd1);
            mem_busy = 1'b0;
        end
        consume = inst_valid & ~s;
        if (consume) begin
            check("sb_depth", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_pc", pc, e.pc);
                check("sb_inst", inst, e.inst);
            end
        end
        if (consume && b) begin
            // everything fetched but not yet presented is wrong-path
            exp_q.delete();
            if (!ack && bus.mem_req) squash = 1'b1;
        end else if (ack) begin
            if (squash) squash = 1'b0;
            else exp_q.push_back('{bus.mem_addr, bus.mem_addr ^ KEY});
        end
        stall = s;
        br = b;
        br_addr = ba;
        bus.mem_ack = ack;
        bus.mem_rdata = rd;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[17];

    initial begin
        int   last_v;
        logic found;

        //          stall br    br_addr       req   addr          valid pc
        vecs[0]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 32'h200, 1'b1, 32'h0,   1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h4};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h8};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h10,  1'b1, 32'h8};
        vecs[6]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h10,  1'b1, 32'h8};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h10,  1'b1, 32'h8};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'hC};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h14,  1'b1, 32'h10};
        vecs[10] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h18,  1'b1, 32'h14};
        vecs[11] = '{1'b0, 1'b1, 32'h300, 1'b0, 32'h1C,  1'b1, 32'h14};
        vecs[12] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h300, 1'b0, 32'h14};
        vecs[13] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h304, 1'b1, 32'h300};
        vecs[14] = '{1'b0, 1'b1, 32'h41,  1'b1, 32'h308, 1'b1, 32'h304};
        vecs[15] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h40,  1'b0, 32'h304};
        vecs[16] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h44,  1'b1, 32'h40};

        // zero-wait stream, stall into the skid, redirects
        do_reset();
        check("rst_inst", inst, NOP);
        for (int i = 0; i < 17; i++) begin
            check($sformatf("v%0d_req", i), 32'(bus.mem_req), 32'(vecs[i].exp_req));
            check($sformatf("v%0d_addr", i), bus.mem_addr, vecs[i].exp_addr);
            check($sformatf("v%0d_valid", i), 32'(inst_valid), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
            step(vecs[i].stall, vecs[i].br, vecs[i].br_addr);
        end

        // two-cycle memory: one valid instruction every third cycle
        do_reset();
        mem_lat = 2;
        last_v = -1;
        for (int c = 0; c < 16; c++) begin
            if (inst_valid) begin
                if (last_v >= 0) check("lat2_spacing", 32'(c - last_v), 32'd3);
                last_v = c;
            end
            step(1'b0, 1'b0, 32'h0);
        end

        // redirect while a request is outstanding: squashed via DROP
        do_reset();
        mem_lat = 2;
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            if (inst_valid && pc == 32'h4) found = 1'b1;
            else step(1'b0, 1'b0, 32'h0);
        end
        check("wait_pc4", 32'(found), 32'd1);
        step(1'b0, 1'b1, 32'h100);
        check("drop_req", 32'(bus.mem_req), 32'd1);
        check("drop_addr", bus.mem_addr, 32'h8);
        check("drop_bubble", 32'(inst_valid), 32'd0);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (bus.mem_req && bus.mem_addr != 32'h8) found = 1'b1;
            else step(1'b0, 1'b0, 32'h0);
        end
        check("after_drop_addr", bus.mem_addr, 32'h100);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (inst_valid) found = 1'b1;
            else step(1'b0, 1'b0, 32'h0);
        end
        check("after_drop_valid", 32'(found), 32'd1);
        check("after_drop_pc", pc, 32'h100);

        // fetch address wraps past 32'hFFFF_FFFC
        do_reset();
        mem_lat = 0;
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        check("wrap_start_valid", 32'(inst_valid), 32'd1);
        step(1'b0, 1'b1, 32'hFFFF_FFF8);
        check("wrap_addr_f8", bus.mem_addr, 32'hFFFF_FFF8);
        step(1'b0, 1'b0, 32'h0);
        check("wrap_addr_fc", bus.mem_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0);
        check("wrap_addr_0", bus.mem_addr, 32'h0);
        check("wrap_pc_fc", pc, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0);
        check("wrap_pc_0", pc, 32'h0);
        check("wrap_inst_0", inst, KEY);

        // async reset with fpc at 32'hFFFF_FFFC and a request in flight
        do_reset();
        mem_lat = 0;
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'hFFFF_FFF0);
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            if (bus.mem_req && bus.mem_addr == 32'hFFFF_FFFC) found = 1'b1;
            else step(1'b0, 1'b0, 32'h0);
        end
        check("wait_fc_req", 32'(found), 32'd1);
        mem_lat = 3;
        step(1'b1, 1'b0, 32'h0);
        check("pre_rst_valid", 32'(inst_valid), 32'd1);
        check("pre_rst_pc", pc, 32'hFFFF_FFF8);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req", 32'(bus.mem_req), 32'd0);
        check("arst_addr", bus.mem_addr, 32'h0);
        check("arst_pc", pc, 32'h0);
        check("arst_inst", inst, NOP);
        check("arst_valid", 32'(inst_valid), 32'd0);
        clear_model();
        mem_lat = 0;
        stall = 1'b0;
        br = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'hBADB_AD00;
        check("idle_req", 32'(bus.mem_req), 32'd0);
        @(posedge clk);
        #1 bus.mem_ack = 1'b0;
        check("stale_valid", 32'(inst_valid), 32'd0);
        check("stale_inst", inst, NOP);
        check("first_req", 32'(bus.mem_req), 32'd1);
        check("first_addr", bus.mem_addr, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        check("post_rst_valid", 32'(inst_valid), 32'd1);
        check("post_rst_inst", inst, KEY);
        step(1'b0, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage of the five-stage RISC-V CPU. Generates the PC, fetches 32-bit instructions over a req/ack instruction-memory port, and presents `pc`/`inst` to the decode stage. It accepts the branch/jump redirect (`br`, `br_addr`) that decode computes combinationally. In-flight wrong-path fetches are squashed, and decode stalls are absorbed with a one-entry skid buffer.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP_INST`, default 32'h0000_0013 (`addi x0,x0,0`): instruction driven on `inst` for bubbles.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `stall`  in  1  decode cannot accept; hold `pc`/`inst`/`inst_valid`.
- `br`  in  1  redirect request from decode; honoured only when `inst_valid`=1 and `stall`=0.
- `br_addr`  in  32  redirect target; bits [1:0] forced to 00.
- `mem_req`  out  1  fetch request; once raised it stays high with `mem_addr` stable until `mem_ack`.
- `mem_addr`  out  32  fetch address.
- `mem_ack`  in  1  request completed this cycle; may arrive in the same cycle as `mem_req` (zero-wait memory).
- `mem_rdata`  in  32  instruction; valid only when `mem_ack`=1.
- `pc`  out  32  address of `inst`.
- `inst`  out  32  instruction to decode.
- `inst_valid`  out  1  `inst` is a real instruction, not a bubble.

## Operation
Registers:
- `fpc`: next fetch address.
- Output slot: `pc`, `inst`, `inst_valid`.
- Skid: `sk_pc`, `sk_inst`.
- `drop_addr`.
- State: IDLE, FETCH, HOLD, DROP.

`mem_addr` = `drop_addr` in DROP, otherwise `fpc`. `mem_req` = 1 in FETCH and DROP only.

IDLE: unconditionally go to FETCH.

FETCH, first matching rule wins:
- Redirect (`br`, `inst_valid`, !`stall`):
  - `fpc` <= `br_addr`; slot <= bubble.
  - If `mem_ack`: stay in FETCH, `mem_rdata` discarded.
  - Otherwise: `drop_addr` <= `fpc`, go to DROP.
- `mem_ack`, with (!`stall` or !`inst_valid`): slot <= {`fpc`, `mem_rdata`, 1}; `fpc` += 4.
- `mem_ack` & `stall` & `inst_valid`: skid <= {`fpc`, `mem_rdata`}; `fpc` += 4; go to HOLD.
- !`mem_ack` & !`stall`: slot <= bubble.
- Otherwise: hold.

HOLD (skid full, no request):
- `stall`: hold.
- !`stall` & redirect: skid discarded; `fpc` <= `br_addr`; slot <= bubble; go to FETCH.
- !`stall`, no redirect: slot <= skid; go to FETCH.

DROP (completing the squashed request):
- `mem_ack`: data discarded; go to FETCH at `fpc`.
- !`stall`: slot <= bubble.

Bubble = {`pc` unchanged, `inst`=`NOP_INST`, `inst_valid`=0}. `br` is ignored while `inst_valid`=0.

Arithmetic: `fpc` += 4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.

## Timing
- Reset values: state IDLE, `fpc`=`RESET_PC`, `pc`=`RESET_PC`, `inst`=`NOP_INST`, `inst_valid`=0, `mem_req`=0, `mem_addr`=`RESET_PC`, skid=0, `drop_addr`=0.
- First `mem_req` occurs in the 2nd cycle after `rst_n` deasserts (IDLE lasts one cycle).
- Latency: `mem_ack` in cycle N → `inst`/`inst_valid` updated in cycle N+1.
- Throughput: one instruction per cycle with zero-wait memory.
- Redirect penalty: with zero-wait memory, redirect in cycle N → target fetched in N+1 and visible in N+2. Each cycle spent in DROP adds one cycle.
- Reset asserted mid-request: all state returns to reset values immediately. A later stale `mem_ack` while in IDLE is ignored; memory must also be reset.
- `br` and `mem_ack` in the same cycle: redirect wins and fetched data is discarded.
- Skid full and `stall` held indefinitely: no request issued, no data lost.

## Structure
- Shared `defines.v` gets: `InstAddrBus`, `InstBus`, `NOP_INST` encoding, and the 2-bit fetch-state encodings (`IF_IDLE`, `IF_FETCH`, `IF_HOLD`, `IF_DROP`).
- One sub-module, `fetch_skid`: a 1-entry pc+inst holding register with load/flush/valid.
- FSM and PC logic stay in `inst_fetch`.

## Test plan
- Reset release, zero-wait memory returning `mem_rdata`=addr ^ 32'hA5A5_A5A5 → `mem_addr` 0,4,8,… on consecutive cycles; `inst_valid`=1 from 3rd cycle; `pc`/`inst` pairs match.
- Memory with 2-cycle ack latency → each `mem_req` held with stable `mem_addr` until ack; two bubble cycles between valid instructions.
- `stall`=1 for 3 cycles while `pc`=8 → slot holds 8, address 12 in skid, `mem_req`=0. Stall release → `pc`=12, then fetching resumes at 16, with no duplicated or skipped addresses.
- `br`=1, `br_addr`=32'h100 while `pc`=4 and request to 8 is outstanding (ack 2 cycles later) → DROP holds `mem_addr`=8 until ack. Data for 8 never appears. Next request is 32'h100, and `pc`=32'h100 is the next valid output.
- `br` during HOLD with `stall` dropped → skid content is never output; next fetch is at `br_addr`. `br` while `inst_valid`=0 → ignored.
- `rst_n` low mid-request; `fpc` at 32'hFFFF_FFFC → outputs return to reset values asynchronously. Separately, the fetch after 32'hFFFF_FFFC goes to address 0.
